// File: rtl/spi2i2c_req_arbiter.sv
// Round-robin arbiter/sequencer feeding single-byte transfers to the SPI-to-I2C bridge.
// Optional WAIT-state abort counter enabled by defining SPI2I2C_ARB_TIMEOUT_EN.
module spi2i2c_req_arbiter #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [8*NREQ-1:0]        req_data,
  output logic [NREQ-1:0]          ack,
  output logic [7:0]               br_data,
  output logic                     br_start,
  input  logic                     br_done,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     timeout
);
  localparam int GW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_e;
  state_e state_q, state_d;

  logic [NREQ-1:0] ack_q, ack_d;
  logic [7:0]      br_data_q, br_data_d;
  logic            br_start_q, br_start_d;
  logic            busy_q, busy_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;
  logic [GW-1:0]   pick;
  logic            found;
  logic            to_hit;
  int              idx;

  // Scan upward from the slot after the last winner, wrapping modulo NREQ.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last_q) + i) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

`ifdef SPI2I2C_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CW-1:0] cnt_q;
  logic          timeout_q;

  assign to_hit = (state_q == WAIT) && !br_done && (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= to_hit;
      if (state_q == LAUNCH)    cnt_q <= '0;
      else if (state_q == WAIT) cnt_q <= cnt_q + CW'(1);
    end
  end

  assign timeout = timeout_q;
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT:    if (br_done || to_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so every port is a flop.
  always_comb begin
    br_start_d = (state_q == IDLE) && (state_d == LAUNCH);
    busy_d     = (state_d != IDLE);
    ack_d      = '0;
    grant_d    = grant_q;
    br_data_d  = br_data_q;
    last_d     = last_q;
    if (state_q == IDLE && found) begin
      grant_d   = pick;
      br_data_d = req_data[int'(pick)*8 +: 8];
    end
    if (state_q == WAIT && state_d == DONE) begin
      ack_d[grant_q] = 1'b1;
      last_d         = grant_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q      <= '0;
      br_data_q  <= 8'h00;
      br_start_q <= 1'b0;
      busy_q     <= 1'b0;
      grant_q    <= '0;
      last_q     <= GW'(NREQ - 1);
    end else begin
      ack_q      <= ack_d;
      br_data_q  <= br_data_d;
      br_start_q <= br_start_d;
      busy_q     <= busy_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
    end
  end

  assign ack      = ack_q;
  assign br_data  = br_data_q;
  assign br_start = br_start_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;
endmodule
